// File: rtl/weights_fetch_scheduler_pkg.sv
// Shared types for the weights fetch scheduler and its descriptor source.
package weights_fetch_scheduler_pkg;

  localparam int unsigned WFS_ADDR_W = 32;
  localparam int unsigned WFS_LEN_W  = 23;
  localparam int unsigned WFS_IT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } wfs_state_e;

  // Layer descriptor as produced by the CSR block.
  typedef struct packed {
    logic [WFS_ADDR_W-1:0] base;
    logic [WFS_LEN_W-1:0]  bytes;
    logic [WFS_IT_W-1:0]   it_1;
    logic                  last_layer;
  } layer_desc_t;

endpackage

// File: rtl/weights_fetch_scheduler_counter.sv
// Up/down counter: simultaneous inc/dec cancel, inc at MAX is dropped and flagged,
// dec at zero is dropped.
module up_down_sat_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned MAX   = 2,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero_c,
  output logic             sat_c
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count and saturation detect.
  always_comb begin
    count_d = count_q;
    sat_c   = 1'b0;
    if (inc && !dec) begin
      if (count_q == WIDTH'(MAX)) begin
        sat_c = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else if (dec && !inc) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= WIDTH'(INIT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign zero_c = (count_q == '0);

endmodule

// File: rtl/weights_fetch_scheduler.sv
// Turns a layer descriptor into credit-throttled weight DMA commands and tracks
// in-flight bank images until the layer drains.
module weights_fetch_scheduler
  import weights_fetch_scheduler_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH = WFS_ADDR_W,
  parameter int unsigned  LEN_WIDTH  = WFS_LEN_W,
  parameter int unsigned  BITS_IT    = WFS_IT_W,
  parameter int unsigned  N_BANKS    = 2,
  localparam int unsigned BITS_CRED  = $clog2(N_BANKS + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_cfg_valid,
  output logic                  s_cfg_ready,
  input  logic [ADDR_WIDTH-1:0] s_cfg_base,
  input  logic [LEN_WIDTH-1:0]  s_cfg_bytes,
  input  logic [BITS_IT-1:0]    s_cfg_it_1,
  input  logic                  s_cfg_last_layer,
  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_cmd_addr,
  output logic [LEN_WIDTH-1:0]  m_cmd_len,
  output logic                  m_cmd_last,
  input  logic                  fill_done,
  input  logic                  bank_release,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  all_done,
  output logic [BITS_CRED-1:0]  credits,
  output logic                  err_credit
);

  wfs_state_e           state_q, state_d;
  layer_desc_t          desc_q, desc_d;
  logic [WFS_IT_W-1:0]  it_cnt_q, it_cnt_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 layer_done_q, layer_done_d;
  logic                 all_done_q, all_done_d;
  logic                 err_credit_q, err_credit_d;
  logic [BITS_CRED-1:0] pending;
  logic                 cred_zero_c, cred_sat_c;
  logic                 pend_zero_c, pend_sat_unused;
  logic                 cfg_hs_c, cmd_hs_c, cmd_last_c;

  // Handshakes and command decode; valid depends on registered state only.
  assign cfg_hs_c    = s_cfg_valid && cfg_ready_q;
  assign m_cmd_valid = (state_q == ST_ISSUE) && !cred_zero_c;
  assign cmd_hs_c    = m_cmd_valid && m_cmd_ready;
  assign cmd_last_c  = (it_cnt_q == desc_q.it_1);

  // Free rotator banks: taken by a command, returned by a bank release.
  up_down_sat_counter #(
    .WIDTH(BITS_CRED),
    .MAX  (N_BANKS),
    .INIT (N_BANKS)
  ) u_credits (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (bank_release),
    .dec   (cmd_hs_c),
    .count (credits),
    .zero_c(cred_zero_c),
    .sat_c (cred_sat_c)
  );

  // Images commanded but not yet fully received by the rotator.
  up_down_sat_counter #(
    .WIDTH(BITS_CRED),
    .MAX  (N_BANKS),
    .INIT (0)
  ) u_pending (
    .clk   (aclk),
    .rst_n (aresetn),
    .inc   (cmd_hs_c),
    .dec   (fill_done),
    .count (pending),
    .zero_c(pend_zero_c),
    .sat_c (pend_sat_unused)
  );

  // Next-state and registered-output logic; desc.base doubles as the running address.
  always_comb begin
    state_d      = state_q;
    desc_d       = desc_q;
    it_cnt_d     = it_cnt_q;
    layer_done_d = 1'b0;
    all_done_d   = 1'b0;
    err_credit_d = err_credit_q | cred_sat_c;
    case (state_q)
      ST_IDLE: begin
        if (cfg_hs_c) begin
          desc_d.base       = WFS_ADDR_W'(s_cfg_base);
          desc_d.bytes      = WFS_LEN_W'(s_cfg_bytes);
          desc_d.it_1       = WFS_IT_W'(s_cfg_it_1);
          desc_d.last_layer = s_cfg_last_layer;
          it_cnt_d          = '0;
          state_d           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_hs_c) begin
          desc_d.base = desc_q.base + WFS_ADDR_W'(desc_q.bytes);
          if (cmd_last_c) begin
            state_d = ST_DRAIN;
          end else begin
            it_cnt_d = it_cnt_q + WFS_IT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pend_zero_c || ((pending == BITS_CRED'(1)) && fill_done)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        layer_done_d = 1'b1;
        all_done_d   = desc_q.last_layer;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      desc_q       <= '0;
      it_cnt_q     <= '0;
      cfg_ready_q  <= 1'b0;
      layer_done_q <= 1'b0;
      all_done_q   <= 1'b0;
      err_credit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      desc_q       <= desc_d;
      it_cnt_q     <= it_cnt_d;
      cfg_ready_q  <= cfg_ready_d;
      layer_done_q <= layer_done_d;
      all_done_q   <= all_done_d;
      err_credit_q <= err_credit_d;
    end
  end

  assign s_cfg_ready = cfg_ready_q;
  assign m_cmd_addr  = ADDR_WIDTH'(desc_q.base);
  assign m_cmd_len   = LEN_WIDTH'(desc_q.bytes);
  assign m_cmd_last  = cmd_last_c;
  assign busy        = (state_q != ST_IDLE);
  assign layer_done  = layer_done_q;
  assign all_done    = all_done_q;
  assign err_credit  = err_credit_q;

endmodule

// File: tb/tb_weights_fetch_scheduler.sv
// Scoreboard bench for weights_fetch_scheduler: directed layers, expected commands
// and layer completions queued at stimulus time, checked by a monitor process.
module tb_weights_fetch_scheduler;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 23;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          last;
  } cmd_t;

  logic          aclk, aresetn;
  logic          s_cfg_valid, s_cfg_ready;
  logic [AW-1:0] s_cfg_base;
  logic [LW-1:0] s_cfg_bytes;
  logic [IW-1:0] s_cfg_it_1;
  logic          s_cfg_last_layer;
  logic          m_cmd_valid, m_cmd_ready;
  logic [AW-1:0] m_cmd_addr;
  logic [LW-1:0] m_cmd_len;
  logic          m_cmd_last;
  logic          fill_done, bank_release;
  logic          busy, layer_done, all_done, err_credit;
  logic [CW-1:0] credits;

  cmd_t exp_cmd[$];
  bit   exp_done[$];
  int   total, bad, hs_cnt;
  int   n_hs, first_hs, lat, n_done, n_all, hs_before;

  weights_fetch_scheduler dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_cfg_valid     (s_cfg_valid),
    .s_cfg_ready     (s_cfg_ready),
    .s_cfg_base      (s_cfg_base),
    .s_cfg_bytes     (s_cfg_bytes),
    .s_cfg_it_1      (s_cfg_it_1),
    .s_cfg_last_layer(s_cfg_last_layer),
    .m_cmd_valid     (m_cmd_valid),
    .m_cmd_ready     (m_cmd_ready),
    .m_cmd_addr      (m_cmd_addr),
    .m_cmd_len       (m_cmd_len),
    .m_cmd_last      (m_cmd_last),
    .fill_done       (fill_done),
    .bank_release    (bank_release),
    .busy            (busy),
    .layer_done      (layer_done),
    .all_done        (all_done),
    .credits         (credits),
    .err_credit      (err_credit)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic last);
    cmd_t c;
    c.addr = a;
    c.len  = l;
    c.last = last;
    exp_cmd.push_back(c);
  endtask

  // Pops the scoreboard whenever the DUT completes a command or a layer.
  task automatic monitor();
    cmd_t c;
    bit   e;
    forever begin
      @(negedge aclk);
      if (aresetn && m_cmd_valid && m_cmd_ready) begin
        hs_cnt++;
        if (exp_cmd.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_extra: got addr 0x%0h with no expected command", m_cmd_addr);
        end else begin
          c = exp_cmd.pop_front();
          check("cmd", {m_cmd_addr, m_cmd_len, m_cmd_last}, {c.addr, c.len, c.last});
        end
      end
      if (aresetn && layer_done) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_extra: got layer_done with none expected");
        end else begin
          e = exp_done.pop_front();
          check("all_done_with_layer", all_done, e);
        end
      end
      if (aresetn && all_done && !layer_done) begin
        total++;
        bad++;
        $display("FAIL all_done_alone: got all_done=1 layer_done=0");
      end
    end
  endtask

  task automatic start_layer(input logic [AW-1:0] b, input logic [LW-1:0] n,
                             input logic [IW-1:0] it1, input logic ll);
    int w;
    w = 0;
    s_cfg_base       = b;
    s_cfg_bytes      = n;
    s_cfg_it_1       = it1;
    s_cfg_last_layer = ll;
    s_cfg_valid      = 1'b1;
    while (!s_cfg_ready && w < 50) begin
      tick();
      w++;
    end
    check("cfg_ready", s_cfg_ready, 1);
    tick();
    s_cfg_valid = 1'b0;
  endtask

  // Rotator model: fill fill_lat cycles after each command, release rel_lat after fill.
  task automatic run_rot(input int budget, input int fill_lat, input int rel_lat, input bit do_rel,
                         output int o_hs, output int o_first, output int o_lat,
                         output int o_done, output int o_all);
    bit fp[64];
    bit rp[64];
    bit hs;
    int last_fill, done_c;
    fp = '{default: 1'b0};
    rp = '{default: 1'b0};
    o_hs = 0; o_first = -1; o_done = 0; o_all = 0;
    last_fill = -1; done_c = -1;
    for (int c = 0; c < budget && c < 64; c++) begin
      fill_done    = fp[c];
      bank_release = rp[c];
      if (fp[c]) last_fill = c;
      hs = m_cmd_valid && m_cmd_ready;
      tick();
      if (hs) begin
        o_hs++;
        if (o_first < 0) o_first = c;
        if (c + fill_lat < 64) fp[c + fill_lat] = 1'b1;
        if (do_rel && (c + fill_lat + rel_lat < 64)) rp[c + fill_lat + rel_lat] = 1'b1;
      end
      if (layer_done) begin
        o_done++;
        if (done_c < 0) done_c = c;
      end
      if (all_done) o_all++;
    end
    fill_done    = 1'b0;
    bank_release = 1'b0;
    o_lat = (done_c >= 0 && last_fill >= 0) ? (done_c - last_fill + 1) : -1;
  endtask

  initial begin
    total = 0; bad = 0; hs_cnt = 0;
    aresetn = 1'b0;
    s_cfg_valid = 1'b0; s_cfg_base = '0; s_cfg_bytes = '0; s_cfg_it_1 = '0;
    s_cfg_last_layer = 1'b0; m_cmd_ready = 1'b0; fill_done = 1'b0; bank_release = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    tick(); tick();
    check("rst_ready", s_cfg_ready, 0);
    check("rst_valid", m_cmd_valid, 0);
    check("rst_credits", credits, 2);
    check("rst_busy", busy, 0);
    check("rst_flags", {layer_done, all_done, err_credit}, 3'b000);
    aresetn = 1'b1;
    tick();
    check("idle_ready", s_cfg_ready, 1);

    // Basic layer
    m_cmd_ready = 1'b1;
    push_cmd(32'h1000, 23'h200, 0); push_cmd(32'h1200, 23'h200, 0);
    push_cmd(32'h1400, 23'h200, 0); push_cmd(32'h1600, 23'h200, 1);
    exp_done.push_back(1'b0);
    start_layer(32'h1000, 23'h200, 16'd3, 1'b0);
    check("first_valid_latency", m_cmd_valid, 1);
    run_rot(40, 2, 5, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("basic_cmds", n_hs, 4);
    check("basic_done_count", n_done, 1);
    check("basic_fill_to_done", lat, 2);
    check("basic_credits_end", credits, 2);
    check("basic_busy_end", busy, 0);

    // Credit throttle
    push_cmd(32'h2000, 23'h100, 0); push_cmd(32'h2100, 23'h100, 0);
    push_cmd(32'h2200, 23'h100, 0); push_cmd(32'h2300, 23'h100, 1);
    exp_done.push_back(1'b0);
    start_layer(32'h2000, 23'h100, 16'd3, 1'b0);
    run_rot(10, 1, 0, 1'b0, n_hs, first_hs, lat, n_done, n_all);
    check("throttle_cmds", n_hs, 2);
    check("throttle_valid", m_cmd_valid, 0);
    check("throttle_credits", credits, 0);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("throttle_resume_valid", m_cmd_valid, 1);
    run_rot(30, 1, 3, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("throttle_rest_cmds", n_hs, 2);
    check("throttle_done", n_done, 1);
    check("credits_persist", credits, 1);
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check("credits_restored", credits, 2);

    // Simultaneous events
    m_cmd_ready = 1'b0;
    push_cmd(32'h3000, 23'h80, 0); push_cmd(32'h3080, 23'h80, 0); push_cmd(32'h3100, 23'h80, 1);
    exp_done.push_back(1'b0);
    start_layer(32'h3000, 23'h80, 16'd2, 1'b0);
    m_cmd_ready = 1'b1; tick(); m_cmd_ready = 1'b0;
    check("sim_credits_pre", credits, 1);
    m_cmd_ready = 1'b1; bank_release = 1'b1; fill_done = 1'b1;
    tick();
    m_cmd_ready = 1'b0; bank_release = 1'b0; fill_done = 1'b0;
    check("sim_credits_cancel", credits, 1);
    m_cmd_ready = 1'b1; tick(); m_cmd_ready = 1'b0;
    check("sim_credits_zero", credits, 0);
    fill_done = 1'b1; tick(); fill_done = 1'b0; tick();
    check("sim_pending_cancel", {busy, layer_done}, 2'b10);
    fill_done = 1'b1; tick(); fill_done = 1'b0; tick();
    check("sim_layer_done", layer_done, 1);
    bank_release = 1'b1; tick(); tick(); bank_release = 1'b0;
    check("sim_credits_end", credits, 2);

    // Backpressure
    push_cmd(32'h4000, 23'h40, 0); push_cmd(32'h4040, 23'h40, 1);
    exp_done.push_back(1'b0);
    start_layer(32'h4000, 23'h40, 16'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {m_cmd_valid, m_cmd_addr, m_cmd_len, m_cmd_last},
            {1'b1, 32'h4000, 23'h40, 1'b0});
      tick();
    end
    m_cmd_ready = 1'b1;
    run_rot(20, 1, 1, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("bp_first_ready_hs", first_hs, 0);
    check("bp_cmds", n_hs, 2);

    // Single-iteration layer
    push_cmd(32'h5000, 23'h10, 1);
    exp_done.push_back(1'b0);
    start_layer(32'h5000, 23'h10, 16'd0, 1'b0);
    check("it0_last", {m_cmd_valid, m_cmd_last}, 2'b11);
    run_rot(15, 1, 1, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("it0_cmds", n_hs, 1);
    check("it0_done", n_done, 1);

    // Address wrap
    push_cmd(32'hFFFF_FF00, 23'h200, 0); push_cmd(32'h0000_0100, 23'h200, 1);
    exp_done.push_back(1'b0);
    start_layer(32'hFFFF_FF00, 23'h200, 16'd1, 1'b0);
    run_rot(15, 1, 1, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("wrap_cmds", n_hs, 2);

    // Last layer
    push_cmd(32'h6000, 23'h20, 0); push_cmd(32'h6020, 23'h20, 1);
    exp_done.push_back(1'b1);
    start_layer(32'h6000, 23'h20, 16'd1, 1'b1);
    run_rot(15, 1, 1, 1'b1, n_hs, first_hs, lat, n_done, n_all);
    check("last_done_count", n_done, 1);
    check("last_all_count", n_all, 1);
    check("last_credits", credits, 2);

    // Spurious release sets sticky error
    bank_release = 1'b1; tick(); bank_release = 1'b0;
    check("err_set", {err_credit, credits}, {1'b1, 2'd2});
    tick(); tick(); tick();
    check("err_sticky", err_credit, 1);

    // Reset mid-ISSUE
    m_cmd_ready = 1'b0;
    start_layer(32'h7000, 23'h100, 16'd3, 1'b0);
    check("pre_rst_valid", m_cmd_valid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_async_valid", m_cmd_valid, 0);
    check("rst_async_state", {busy, err_credit, s_cfg_ready, credits}, {3'b000, 2'd2});
    tick(); tick();
    aresetn = 1'b1;
    tick();
    check("post_rst", {s_cfg_ready, busy, m_cmd_valid, credits}, {3'b100, 2'd2});

    check("sb_cmd_drained", exp_cmd.size(), 0);
    check("sb_done_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/weights_fetch_scheduler.md
Name: weights_fetch_scheduler

Overview:
- Sequences the weight DMA for one layer at a time. It turns a layer descriptor into per-iteration DMA read commands, and each command fetches one weight bank image (config beat plus weights).
- It throttles commands with credits so that no more than N_BANKS images are in flight into the ping-pong weight rotator.
- It sits between the layer-descriptor source (controller/CSR) and the weights DMA. It observes the rotator's input-last and output-last handshakes.

Parameters:
- ADDR_WIDTH, 32, DMA byte-address width.
- LEN_WIDTH, 23, DMA byte-length width.
- BITS_IT, 16, width of the iterations-per-layer field.
- N_BANKS, 2, rotator banks (credit ceiling).
- BITS_CRED, $clog2(N_BANKS+1), credit/pending counter width (localparam).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_cfg_valid  in  1  layer descriptor valid
- s_cfg_ready  out  1  descriptor accepted
- s_cfg_base  in  ADDR_WIDTH  byte address of first weight image
- s_cfg_bytes  in  LEN_WIDTH  bytes per image (nonzero)
- s_cfg_it_1  in  BITS_IT  iterations minus one
- s_cfg_last_layer  in  1  final layer of network
- m_cmd_valid  out  1  DMA command valid
- m_cmd_ready  in  1  DMA accepts command
- m_cmd_addr  out  ADDR_WIDTH  command address
- m_cmd_len  out  LEN_WIDTH  command length (bytes)
- m_cmd_last  out  1  final command of layer
- fill_done  in  1  pulse: rotator s_axis last handshake (image fully received)
- bank_release  in  1  pulse: rotator m_axis last handshake (bank consumed)
- busy  out  1  state != IDLE
- layer_done  out  1  one-cycle pulse
- all_done  out  1  one-cycle pulse, coincident with layer_done of last layer
- credits  out  BITS_CRED  free banks
- err_credit  out  1  sticky: release received with credits==N_BANKS

Behaviour:
- Reset (async assert, sync deassert assumed upstream) sets:
  - state=IDLE
  - credits=N_BANKS, pending=0, it_cnt=0
  - m_cmd_valid=0, s_cfg_ready=0 until IDLE is registered, then 1
  - layer_done=all_done=0, err_credit=0, busy=0
  - addr/len/it_1/last_layer registers to 0
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: s_cfg_ready=1. On cfg handshake, capture base, bytes, it_1 and last_layer. Set it_cnt=0, go to ISSUE. m_cmd_valid rises the cycle after the handshake.
  - ISSUE: m_cmd_valid = (credits!=0), so it depends only on registers.
    - m_cmd_addr = current address; m_cmd_last = (it_cnt==it_1).
    - On command handshake: address += bytes (modulo 2^ADDR_WIDTH), it_cnt++, credits--, pending++.
    - If m_cmd_last was set, go to DRAIN.
  - DRAIN: wait for pending==0. A fill_done in the same cycle that pending==1 counts, so the FSM moves to DONE on the next edge.
  - DONE: one cycle. Pulse layer_done, and pulse all_done if last_layer. Go to IDLE.
- Valid stability: once m_cmd_valid=1, it and the command fields stay constant until the handshake. Credits never decrease without a handshake.
- credits update:
  - handshake and bank_release in the same cycle: unchanged
  - handshake alone: -1
  - release alone: +1
  - release while credits==N_BANKS: ignore, set err_credit
- Credits persist across layers. A bank still held by the rotator from the previous layer withholds its credit.
- pending update: +1 on handshake, -1 on fill_done, unchanged if both. fill_done while pending==0 is ignored.
- Throughput: one command per cycle while credits allow.
- Latency:
  - cfg handshake -> first m_cmd_valid: 1 cycle.
  - last fill_done -> layer_done: 2 cycles (DRAIN->DONE edge, then DONE output registered).
- Boundary cases:
  - it_1=0 gives a single command with m_cmd_last=1.
  - it_1=2^BITS_IT-1 runs the full count without it_cnt overflow; compare uses equality before the increment.
- Reset mid-operation: all state is lost and any in-flight DMA is the system's responsibility. Credits return to N_BANKS.
- All outputs are registered or decoded from registered state only. No combinational path from m_cmd_ready to m_cmd_valid.

Decomposition:
- Shared package holds:
  - the FSM state enum type
  - a packed struct for the layer descriptor (base, bytes, it_1, last_layer), so the CSR block and the scheduler share one definition.
- One natural sub-module: up_down_sat_counter, an up/down counter with simultaneous-event cancellation and a saturation flag. It is instantiated twice, for credits (init N_BANKS) and pending (init 0).

Test Plan:
- Basic layer: base=0x1000, bytes=0x200, it_1=3, release each bank 5 cycles after its fill_done.
  - Commands issue at addresses 0x1000, 0x1200, 0x1400, 0x1600, with m_cmd_last only on the 4th.
  - layer_done fires once, 2 cycles after the 4th fill_done.
- Credit throttle: it_1=3 with no bank_release.
  - Exactly 2 commands issue, then m_cmd_valid=0 and credits=0.
  - One release pulse gives the 3rd command one cycle later.
- Simultaneous events: with credits=1, handshake and bank_release in the same cycle.
  - credits stays 1.
  - fill_done together with handshake leaves pending unchanged.
- Backpressure: hold m_cmd_ready=0 for 10 cycles.
  - valid, addr, len and last stay stable.
  - The handshake happens on the first ready cycle.
- Edge configuration, in three parts:
  - it_1=0 gives one command with last=1.
  - base=0xFFFF_FF00, bytes=0x200, it_1=1 gives a second address of 0x0000_0100 (wrap).
  - Last layer: all_done coincides with layer_done.
- Error and reset, in two parts:
  - A release at credits=2 sets err_credit sticky with credits staying 2.
  - Asserting aresetn=0 mid-ISSUE drops m_cmd_valid asynchronously. After release, the block returns to IDLE with credits=2 and s_cfg_ready=1.
